// File: rtl/conv_relu_pool_engine.sv
// 3x3 convolution engine with zero padding, bias, round-half-up, ReLU and
// saturation over NKER run-time kernels, followed by an optional 2x2 stride-2
// max-pool pass. Image and result memories are external; the engine issues
// registered addresses and samples combinational read data one edge later.
//
// Handshake: ready is a level start request sampled only in IDLE; busy rises
// on the accepting edge and stays high until the DONE cycle, where done pulses
// for exactly one cycle. ready and kw_we are ignored while busy is high.
module conv_relu_pool_engine #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = 20,
  parameter int FRAC  = 16,
  parameter int NKER  = 2,
  localparam int AW   = $clog2(IMG_W * IMG_H),
  localparam int XW   = $clog2(IMG_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  input  logic          pool_en,
  input  logic          kw_we,
  input  logic [1:0]    kw_sel,
  input  logic [3:0]    kw_idx,
  input  logic [DW-1:0] kw_data,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic [2:0]    csel
);
  localparam int YW  = AW - XW;
  localparam int ACW = 2 * DW + 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONV_RD = 3'd1;
  localparam logic [2:0] S_CONV_WR = 3'd2;
  localparam logic [2:0] S_POOL_RD = 3'd3;
  localparam logic [2:0] S_POOL_WR = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic signed [ACW-1:0] RND = {{(ACW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  logic [2:0]    state;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [1:0]    kk;
  logic [3:0]    cnt;
  logic          tap_ok;
  logic          pool_q;
  logic [DW-1:0] pmax;
  logic signed [ACW-1:0] acc;
  // Sized for the largest kernel count and a full 4-bit index; entries that
  // can never be written stay at their reset value of zero.
  logic [DW-1:0] w [4][16];

  // Clamped tap address plus an in-image flag; the flag gates the product.
  function automatic logic [AW:0] conv_tap(input logic [XW-1:0] x,
                                           input logic [YW-1:0] y,
                                           input logic [3:0] t);
    int  tx;
    int  ty;
    logic ok;
    tx = int'(x) + (int'(t) % 3) - 1;
    ty = int'(y) + (int'(t) / 3) - 1;
    ok = (tx >= 0) && (tx < IMG_W) && (ty >= 0) && (ty < IMG_H);
    if (tx < 0) tx = 0;
    else if (tx > IMG_W - 1) tx = IMG_W - 1;
    if (ty < 0) ty = 0;
    else if (ty > IMG_H - 1) ty = IMG_H - 1;
    return {ok, ty[YW-1:0], tx[XW-1:0]};
  endfunction

  // Pool window corner c of the even-aligned window at (x, y).
  function automatic logic [AW-1:0] pool_addr(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y,
                                              input logic [1:0] c);
    return {y[YW-1:1], c[1], x[XW-1:1], c[0]};
  endfunction

  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic [1:0]    nk;
  logic          xe, ye, last, pool_step;

  // Next pixel position: unit step in the conv pass, step of two in the pool pass.
  always_comb begin
    pool_step = (state == S_POOL_WR);
    xe = pool_step ? (px == XW'(IMG_W - 2)) : (px == XW'(IMG_W - 1));
    ye = pool_step ? (py == YW'(IMG_H - 2)) : (py == YW'(IMG_H - 1));
    nx = xe ? '0 : (pool_step ? px + XW'(2) : px + XW'(1));
    ny = py;
    if (xe) ny = ye ? '0 : (pool_step ? py + YW'(2) : py + YW'(1));
    nk = (xe && ye) ? kk + 2'd1 : kk;
    last = xe && ye && (kk == 2'(NKER - 1));
  end

  logic [DW-1:0]         wsel;
  logic [DW-1:0]         bsel;
  logic signed [ACW-1:0] prod_ext;
  logic signed [ACW-1:0] bias_ext;
  logic signed [ACW-1:0] sum;
  logic signed [ACW-1:0] r;
  logic [DW-1:0]         res;

  // Tap product, then bias, rounding, ReLU and saturation of the finished sum.
  always_comb begin
    wsel     = w[kk][cnt];
    bsel     = w[kk][4'd9];
    prod_ext = {{4{1'b0}}, 2*DW'(0)};
    prod_ext = ACW'($signed({{DW{wsel[DW-1]}}, wsel}) * $signed({{DW{idata[DW-1]}}, idata}));
    bias_ext = {{(ACW-DW-FRAC){bsel[DW-1]}}, bsel, {FRAC{1'b0}}};
    sum      = acc + bias_ext + RND;
    r        = sum >>> FRAC;
    if (r[ACW-1])               res = '0;
    else if (|r[ACW-2:DW-1])    res = {1'b0, {(DW-1){1'b1}}};
    else                        res = r[DW-1:0];
  end

  // Weight and bias registers, writable only while no frame is running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 16; j++)
          w[i][j] <= '0;
    end else if (kw_we && !busy && (int'(kw_sel) < NKER) && (kw_idx < 4'd10)) begin
      w[kw_sel][kw_idx] <= kw_data;
    end
  end

  // Frame sequencer: 11-cycle conv pixels, then optional 6-cycle pool pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE; px <= '0; py <= '0; kk <= '0; cnt <= '0;
      tap_ok <= 1'b0; pool_q <= 1'b0; pmax <= '0; acc <= '0;
      busy <= 1'b0; done <= 1'b0; iaddr <= '0; crd <= 1'b0; caddr_rd <= '0;
      cwr <= 1'b0; caddr_wr <= '0; cdata_wr <= '0; csel <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (ready) begin
          busy <= 1'b1; pool_q <= pool_en; state <= S_CONV_RD;
          px <= '0; py <= '0; kk <= '0; cnt <= '0; acc <= '0; csel <= 3'd1;
          {tap_ok, iaddr} <= conv_tap('0, '0, 4'd0);
        end
        S_CONV_RD: begin
          cnt <= cnt + 4'd1;
          if (cnt <= 4'd8) begin
            if (tap_ok) acc <= acc + prod_ext;
            if (cnt != 4'd8) {tap_ok, iaddr} <= conv_tap(px, py, cnt + 4'd1);
          end else begin
            state <= S_CONV_WR; cwr <= 1'b1; caddr_wr <= {py, px}; cdata_wr <= res;
          end
        end
        S_CONV_WR: begin
          cwr <= 1'b0; cnt <= '0;
          if (!last) begin
            state <= S_CONV_RD; px <= nx; py <= ny; kk <= nk; acc <= '0;
            csel <= 3'd1 + 3'(nk);
            {tap_ok, iaddr} <= conv_tap(nx, ny, 4'd0);
          end else if (pool_q) begin
            state <= S_POOL_RD; px <= '0; py <= '0; kk <= '0;
            crd <= 1'b1; csel <= 3'd1; caddr_rd <= '0;
          end else begin
            state <= S_DONE; done <= 1'b1; busy <= 1'b0;
          end
        end
        S_POOL_RD: begin
          cnt <= cnt + 4'd1;
          if (cnt <= 4'd3) begin
            if (cnt == 4'd0 || $signed(cdata_rd) > $signed(pmax)) pmax <= cdata_rd;
            if (cnt != 4'd3) caddr_rd <= pool_addr(px, py, cnt[1:0] + 2'd1);
          end else begin
            state <= S_POOL_WR; crd <= 1'b0; cwr <= 1'b1;
            csel <= 3'(1 + NKER) + 3'(kk);
            caddr_wr <= AW'({py[YW-1:1], px[XW-1:1]});
            cdata_wr <= pmax;
          end
        end
        S_POOL_WR: begin
          cwr <= 1'b0; cnt <= '0;
          if (!last) begin
            state <= S_POOL_RD; px <= nx; py <= ny; kk <= nk;
            crd <= 1'b1; csel <= 3'd1 + 3'(nk); caddr_rd <= {ny, nx};
          end else begin
            state <= S_DONE; done <= 1'b1; busy <= 1'b0;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/conv_relu_pool_engine.md
Name: conv_relu_pool_engine

Overview:
- Parametrised 3x3 convolution engine with zero padding, bias, rounding, ReLU and saturation.
- Runs over NKER run-time-loaded kernels, then optionally applies 2x2 stride-2 max pooling.
- Reads the source image from external image memory and writes layer0 (conv) and layer1 (pool) results to external result memory selected by csel.
- Drop-in successor for the fixed 64x64, single-kernel, hard-coded-weight conv block. Re-arms after each frame.

Parameters:
- IMG_W, 64: image width; power of two, >=4.
- IMG_H, 64: image height; power of two, >=4.
- DW, 20: pixel, weight and result width; signed two's complement with FRAC fraction bits.
- FRAC, 16: fraction bits of pixels, weights and bias.
- NKER, 2: number of kernels, 1..3.
- Derived: AW = log2(IMG_W*IMG_H), XW = log2(IMG_W).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  start request, honoured only in IDLE.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.
- pool_en  in  1  layer1 pass enable; sampled at start.
- kw_we  in  1  weight write strobe.
- kw_sel  in  2  kernel index.
- kw_idx  in  4  0..8 = tap in raster order (top-left first), 9 = bias; 10..15 ignored.
- kw_data  in  DW  weight or bias value.
- iaddr  out  AW  image address {y,x}.
- idata  in  DW  image data, combinational on iaddr.
- crd  out  1  result-memory read enable.
- caddr_rd  out  AW  result read address.
- cdata_rd  in  DW  result read data, combinational on caddr_rd/csel.
- cwr  out  1  result write strobe.
- caddr_wr  out  AW  result write address.
- cdata_wr  out  DW  result write data.
- csel  out  3  result bank select.

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE. All weight/bias registers are cleared to 0. An assertion mid-frame aborts the frame immediately, with no further cwr.
- Weight loading: kw_we accepted only while busy=0. Writes with kw_sel>=NKER or kw_idx>=10 are ignored. Writes while busy=1 are ignored.
- Start: in IDLE, when ready=1 at an edge: busy<=1 and pool_en is latched. ready is ignored while busy=1.
- FSM: IDLE -> CONV_RD -> CONV_WR -> (next pixel) CONV_RD ... -> POOL_RD -> POOL_WR ... -> DONE -> IDLE.
- Pass order: L0 for k=0..NKER-1, each in raster order (y outer, x inner); then, if pool_en=1, L1 for k=0..NKER-1.
- L0 pixel timing: exactly 11 cycles. CONV_RD issues 9 tap addresses on consecutive cycles, each registered. Each idata is sampled on the edge after its address; one drain cycle follows. CONV_WR holds cwr=1 for one cycle.
- Padding: a tap outside the image contributes 0 (product gated). Its iaddr is the coordinate clamped to [0,W-1]x[0,H-1].
- Arithmetic:
  - acc = sum(w*p) over the 9 taps, held at 2*DW+4 bits signed.
  - The bias is sign-extended and left-shifted by FRAC before adding.
  - r = (acc + 2^(FRAC-1)) >>> FRAC, i.e. round half up.
  - If r<0, result = 0 (ReLU). If r>2^(DW-1)-1, result = 2^(DW-1)-1 (saturate).
- L0 write: caddr_wr={y,x}, csel=1+k.
- L1 pixel timing: exactly 6 cycles. POOL_RD holds crd=1 and reads {y,x}, {y,x+1}, {y+1,x}, {y+1,x+1} from csel=1+k, then one compare cycle. POOL_WR writes the signed max.
- L1 write: caddr_wr = zero-extended {y>>1, x>>1} (high bits 0), csel=1+NKER+k. x and y step by 2.
- crd and cwr are never both 1. crd=0 outside POOL_RD.
- End of frame: after the last write, go to DONE for one cycle with done=1 and busy<=0, then IDLE. A new ready starts a new frame using the retained weights.
- Frame latency from the start edge to the done pulse: NKER*W*H*11 + pool_en*NKER*(W*H/4)*6 + 1 cycles.

Test Plan:
- Reset: drive reset low mid-frame -> all outputs 0 within the same cycle; after release no cwr; a later ready starts a clean frame; weights read back as 0 (all-zero output).
- 64x64, NKER=1, center weight 0x10000, bias 0, all pixels 0x01000 -> 4096 L0 writes of 0x01000 (csel=1), 1024 L1 writes of 0x01000 (csel=2), done pulse at start+4096*11+1024*6+1.
- 4x4, all weights 0x10000, all pixels 0x10000, bias 0, pool_en=0 -> corners 0x40000, edges 0x60000, interior saturates to 0x7FFFF; iaddr never exceeds 15.
- ReLU: center weight 0xF0000 (-1.0), bias 0x00010, pixels 0x10000 -> every L0 value 0.
- Rounding: center weight 0x08000, pixel 0x00001 -> 0x00001; pixel 0x00003 -> 0x00002; pixel 0xFFFFF -> 0 (ReLU).
- NKER=2, pool_en=1, kernel 1 bias=0x20000 only; kw_we pulsed during busy with kw_sel=0, kw_idx=4, kw_data=0x10000 -> kernel 0 outputs all 0 (the write is ignored); csel sequence 1, 2, 3, 4; bank 2 and bank 4 values all 0x20000.
